// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, combinational imem addressing, prefetch FIFO, redirect and halt handling.
// Optional perf counters (perf_fetched, perf_bubbles) when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_bubbles
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [2:0]  OP_HALT = 3'b011;

  logic [15:0]   pc, pc_nxt;
  logic [AW-1:0] rptr, rptr_nxt, wptr, wptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          stopped, stopped_nxt;
  logic          pop, enq;
  logic [15:0]   fifo_pc    [DEPTH];
  logic [15:0]   fifo_instr [DEPTH];

  // Outputs derive only from registered state; halted also folds in a pending redirect.
  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? fifo_instr[rptr] : 16'h0000;
  assign out_pc    = out_valid ? fifo_pc[rptr]    : 16'h0000;
  assign halted    = stopped && (count == '0) && !redirect_valid;

  // Next-state: redirect flushes and retargets; otherwise pop/enqueue with halt predecode.
  always_comb begin
    pc_nxt      = pc;
    rptr_nxt    = rptr;
    wptr_nxt    = wptr;
    count_nxt   = count;
    stopped_nxt = stopped;
    pop         = out_valid && out_ready;
    enq         = 1'b0;
    if (redirect_valid) begin
      pc_nxt      = redirect_pc;
      rptr_nxt    = '0;
      wptr_nxt    = '0;
      count_nxt   = '0;
      stopped_nxt = 1'b0;
    end else begin
      enq = !stopped && ((count < CW'(DEPTH)) || pop);
      if (pop) begin
        rptr_nxt  = rptr + AW'(1);
        count_nxt = count_nxt - CW'(1);
      end
      if (enq) begin
        wptr_nxt  = wptr + AW'(1);
        count_nxt = count_nxt + CW'(1);
        if (imem_data[15:13] == OP_HALT) begin
          stopped_nxt = 1'b1;
        end else begin
          pc_nxt = pc + 16'h0001;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      stopped <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      rptr    <= rptr_nxt;
      wptr    <= wptr_nxt;
      count   <= count_nxt;
      stopped <= stopped_nxt;
    end
  end

  // FIFO storage needs no reset: entries are masked by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_pc[wptr]    <= pc;
      fifo_instr[wptr] <= imem_data;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 16'h0000;
      perf_bubbles <= 16'h0000;
    end else begin
      if (enq && (perf_fetched != 16'hFFFF)) begin
        perf_fetched <= perf_fetched + 16'h0001;
      end
      if (out_ready && !out_valid && !halted && (perf_bubbles != 16'hFFFF)) begin
        perf_bubbles <= perf_bubbles + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr, imem_data, out_instr, out_pc, redirect_pc;
  logic        out_valid, out_ready, redirect_valid, halted;
  logic [15:0] imem_addr2, imem_data2, out_instr2, out_pc2;
  logic        out_valid2, halted2;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [15:0] zero16 = 16'h0000;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_bubbles, perf_fetched2, perf_bubbles2;
`endif

  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;
  assign imem_data  = mem[imem_addr];
  assign imem_data2 = mem[imem_addr2];

  fetch_unit #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_unit #(.RESET_PC(16'hFFFF), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .out_valid(out_valid2), .out_ready(one), .out_instr(out_instr2), .out_pc(out_pc2),
    .redirect_valid(zero), .redirect_pc(zero16), .halted(halted2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched2), .perf_bubbles(perf_bubbles2)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected FIFO contents as a queue of {pc, instr}.
  typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
  ent_t        q[$];
  logic [15:0] m_pc;
  bit          m_stopped;
  int          m_fetched, m_bubbles;

  function automatic bit m_halted();
    return m_stopped && (q.size() == 0) && !redirect_valid;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = 16'h0000;
    m_stopped = 1'b0;
    m_fetched = 0;
    m_bubbles = 0;
  endtask

  task automatic model_step();
    ent_t e;
    if (out_ready && q.size() == 0 && !m_halted() && m_bubbles < 65535) m_bubbles++;
    if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc;
      m_stopped = 1'b0;
    end else begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (!m_stopped && q.size() < DEPTH) begin
        e.pc = m_pc;
        e.instr = mem[m_pc];
        q.push_back(e);
        if (m_fetched < 65535) m_fetched++;
        if (e.instr[15:13] == 3'b011) m_stopped = 1'b1;
        else m_pc = m_pc + 16'h0001;
      end
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("out_instr", 32'(out_instr), (q.size() != 0) ? 32'(q[0].instr) : 32'h0);
      check("out_pc",    32'(out_pc),    (q.size() != 0) ? 32'(q[0].pc)    : 32'h0);
      check("imem_addr", 32'(imem_addr), 32'(m_pc));
      check("halted",    32'(halted),    32'(m_halted()));
`ifdef FETCH_PERF_EN
      check("perf_fetched", 32'(perf_fetched), 32'(m_fetched));
      check("perf_bubbles", 32'(perf_bubbles), 32'(m_bubbles));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    #2;
  endtask

  task automatic async_reset_and_release(input logic ready);
    rst_n = 1'b0;
    model_reset();
    #1;
    out_ready = ready;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    for (int a = 0; a < 65536; a++) begin
      w = 16'($urandom);
      if (w[15:13] == 3'b011) w[15] = 1'b1;
      mem[a] = w;
    end
    mem[0] = 16'hA001;
    mem[9] = 16'h6000;
    for (int a = 16; a < 256; a++) begin
      if ($urandom_range(11, 0) == 0) mem[a] = 16'h6000 | 16'($urandom_range(8191, 0));
    end

    rst_n = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk_en = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset and first fetch, plus wrap instance
    check("rst_imem_addr", 32'(imem_addr), 32'h0000);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("wrap_imem_addr", 32'(imem_addr2), 32'hFFFF);
    step();
    check("first_valid", 32'(out_valid), 32'h1);
    check("first_instr", 32'(out_instr), 32'hA001);
    check("first_pc", 32'(out_pc), 32'h0000);
    check("wrap_pc0", 32'(out_pc2), 32'hFFFF);
    check("wrap_instr0", 32'(out_instr2), 32'(mem[16'hFFFF]));
    for (int k = 1; k <= 3; k++) begin
      step();
      check("stream_pc", 32'(out_pc), 32'(k));
      if (k == 1) begin
        check("wrap_pc1", 32'(out_pc2), 32'h0000);
        check("wrap_instr1", 32'(out_instr2), 32'hA001);
      end
    end

    // Back-pressure
    async_reset_and_release(1'b0);
    repeat (5) step();
    check("bp_imem_addr", 32'(imem_addr), 32'h0002);
    check("bp_head_pc", 32'(out_pc), 32'h0000);
    out_ready = 1'b1;
    check("bp_rel_pc0", 32'(out_pc), 32'h0000);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("bp_rel_pc", 32'(out_pc), 32'(k));
    end

    // Redirect with FIFO full and a same-cycle pop
    redirect_valid = 1'b1; redirect_pc = 16'h0003;
    step();
    redirect_valid = 1'b0;
    check("redir_bubble", 32'(out_valid), 32'h0);
    check("redir_addr", 32'(imem_addr), 32'h0003);
    step();
    check("redir_valid", 32'(out_valid), 32'h1);
    check("redir_pc", 32'(out_pc), 32'h0003);

    // Halt at 0x0009
    redirect_valid = 1'b1; redirect_pc = 16'h0007;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    check("halt_addr", 32'(imem_addr), 32'h0009);
    check("halt_head", 32'(out_pc), 32'h0009);
    check("halt_not_yet", 32'(halted), 32'h0);
    step();
    check("halted_set", 32'(halted), 32'h1);
    for (int k = 0; k < 20; k++) begin
      step();
      check("halted_hold", 32'(halted), 32'h1);
      check("halted_addr", 32'(imem_addr), 32'h0009);
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    #1 check("halt_cleared", 32'(halted), 32'h0);
    step();
    redirect_valid = 1'b0;
    check("restart_bubble", 32'(out_valid), 32'h0);
    step();
    check("restart_pc", 32'(out_pc), 32'h0000);
    check("restart_instr", 32'(out_instr), 32'hA001);

    // Async reset mid-stream with two entries buffered
    out_ready = 1'b0;
    repeat (3) step();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_instr", 32'(out_instr), 32'h0);
    check("arst_pc", 32'(out_pc), 32'h0);
    check("arst_halted", 32'(halted), 32'h0);
    check("arst_addr", 32'(imem_addr), 32'h0000);
`ifdef FETCH_PERF_EN
    check("arst_perf_f", 32'(perf_fetched), 32'h0);
    check("arst_perf_b", 32'(perf_bubbles), 32'h0);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    check("arst_restart_pc", 32'(out_pc), 32'h0000);
    check("arst_restart_instr", 32'(out_instr), 32'hA001);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(11, 0) == 0);
      redirect_pc = 16'($urandom_range(255, 0));
      step();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit processor. It holds the program counter and drives the address input of `instruction_memory`, a combinational ROM that returns the addressed word in the same cycle. It buffers fetched words in a small prefetch FIFO and presents them to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute and stops fetching once a `halt` (opcode 3'b011) has been fetched.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `DEPTH`, 2, prefetch FIFO entries; power of two, 2..8.

Ports:
- `clk`  in  1  single clock for the block; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `imem_addr`  out  16  current PC, connected to `instruction_memory.address`.
- `imem_data`  in  16  word returned combinationally by `instruction_memory`.
- `out_valid`  out  1  FIFO head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  16  head instruction; 16'h0000 (NOP) when `out_valid`=0.
- `out_pc`  out  16  address of head instruction; 16'h0000 when `out_valid`=0.
- `redirect_valid`  in  1  execute requests a PC change (taken `bne`, `jmp`).
- `redirect_pc`  in  16  new fetch address.
- `halted`  out  1  halt fetched, FIFO drained, and no redirect pending.

## Operation
- Registers:
  - `pc` (16 b).
  - FIFO of {pc, instr} pairs, `DEPTH` entries, with read/write pointers and an occupancy count.
  - `stopped` flag (1 b).
- Pop: when `out_valid && out_ready`, the head entry is removed at the clock edge.
- Enqueue: occurs when `!stopped && !redirect_valid` and the FIFO has space (count < `DEPTH`, or a pop happens in the same cycle).
  - Writes {`pc`, `imem_data`}.
  - Updates `pc <= pc + 1`; modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- Halt predecode:
  - If an enqueued word has `imem_data[15:13]` == 3'b011, set `stopped` and leave `pc` unchanged.
  - No further enqueues occur until a redirect.
- Redirect (highest priority):
  - Clear the FIFO and set `pc <= redirect_pc`.
  - Clear `stopped`; no enqueue that cycle.
  - A pop handshaken in the same cycle counts as delivered.
- `halted` = `stopped && count==0 && !redirect_valid`. Fetch stays idle indefinitely until a redirect or reset.
- Full FIFO with no pop: `pc` and `imem_addr` hold; no word is lost or duplicated.
- Empty FIFO: `out_valid` is 0, and `out_ready` is ignored.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `pc` = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - FIFO empty, `stopped` = 0.
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0, `halted` = 0.
- Reset asserted mid-operation discards all buffered words immediately, with no further handshake.
- Fetch latency: a word addressed in cycle N is at the FIFO head, with `out_valid` = 1, in cycle N+1 if the FIFO was empty.
- Throughput: with `out_ready` held high, one instruction per cycle and the FIFO never exceeds 1 entry.
- Redirect penalty:
  - `redirect_valid` sampled high at edge E leaves `out_valid` = 0 after E.
  - The target instruction appears after E+1, a one-cycle bubble.
- Back-pressure: `out_instr`/`out_pc` stay stable while `out_valid` = 1 and `out_ready` = 0.
- Outputs are registered or derived from registers only; no combinational path from `out_ready` or `redirect_*` to `out_*`.
- `imem_addr` is the registered `pc`.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds outputs `perf_fetched` (out, 16) and `perf_bubbles` (out, 16), both reset to 0.
  - `perf_fetched` increments on every enqueue.
  - `perf_bubbles` increments in every cycle with `out_ready` = 1 and `out_valid` = 0 while `halted` = 0.
  - Both saturate at 16'hFFFF.
- `FETCH_PERF_EN` undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Reset and first fetch:** memory holds the count program (0x0000 = 16'hA001) with `out_ready` = 1. Release reset; `imem_addr` = 0 in the first cycle. Next cycle `out_valid` = 1, `out_instr` = 16'hA001, `out_pc` = 0, then PCs 1, 2, 3 on consecutive cycles.
- **Back-pressure:** hold `out_ready` = 0 for 5 cycles after reset. The FIFO fills to `DEPTH` = 2 and `imem_addr` holds at 2. Head stays `out_pc` = 0. On release, PCs 0, 1, 2, … are delivered in order with none dropped or duplicated.
- **Redirect:** `redirect_valid` = 1 with `redirect_pc` = 16'h0003 while the FIFO holds 2 entries. Next cycle `out_valid` = 0; the following cycle `out_pc` = 3. A same-cycle pop is delivered once.
- **Halt:** word 16'h6000 at 0x0009. After it is enqueued, `imem_addr` stays 9. Once decode pops it, `halted` = 1 and stays 1 for 20 cycles. A redirect to 0 clears `halted` the same cycle and fetch restarts.
- **Wrap:** `RESET_PC` = 16'hFFFF. Words are delivered with `out_pc` = 16'hFFFF, then 16'h0000.
- **Async reset mid-stream:** drop `rst_n` between edges with 2 entries buffered. All outputs take reset values immediately, and fetch restarts at `RESET_PC`. With `FETCH_PERF_EN`, both counters are also 0.
